// File: rtl/multicycle_ctrl_if.sv
// Control-to-datapath bundle for the multicycle MIPS controller.
// The slave modport is the controller side; the master modport is the datapath side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run_i;
  logic [5:0]       instr_op_i;
  logic             zero_i;
  logic             pc_write_o;
  logic             ir_write_o;
  logic             reg_write_o;
  logic             reg_dst_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic             pc_src_o;
  logic             illegal_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  modport slave (
    input  run_i,
    input  instr_op_i,
    input  zero_i,
    output pc_write_o,
    output ir_write_o,
    output reg_write_o,
    output reg_dst_o,
    output alu_src_a_o,
    output alu_src_b_o,
    output alu_op_o,
    output pc_src_o,
    output illegal_o,
    output state_o,
    output retired_o
  );

  modport master (
    output run_i,
    output instr_op_i,
    output zero_i,
    input  pc_write_o,
    input  ir_write_o,
    input  reg_write_o,
    input  reg_dst_o,
    input  alu_src_a_o,
    input  alu_src_b_o,
    input  alu_op_o,
    input  pc_src_o,
    input  illegal_o,
    input  state_o,
    input  retired_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared-ALU multicycle MIPS datapath,
// with run/idle handshake, illegal-opcode trap and retire counter.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  multicycle_ctrl_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC_R = 3'd3,
    S_EXEC_I = 3'd4,
    S_BRANCH = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t           r_state;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_retired;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_op;
  logic       w_pc_src;
  logic       w_illegal;
  logic       w_is_r;
  logic [2:0] w_exec_op;
  logic [1:0] w_exec_b;
  logic       w_sat;

  assign w_is_r    = (r_op_q == OP_R);
  assign w_exec_op = w_is_r ? 3'b010 :
                     (r_op_q == OP_SLTI) ? 3'b011 : 3'b000;
  assign w_exec_b  = w_is_r ? 2'b00 : 2'b10;
  assign w_sat     = &r_retired;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_op_q    <= '0;
      r_retired <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.run_i) r_state <= S_FETCH;
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_op_q <= bus.instr_op_i;
          unique case (bus.instr_op_i)
            OP_R:              r_state <= S_EXEC_R;
            OP_ADDI, OP_SLTI:  r_state <= S_EXEC_I;
            OP_BEQ:            r_state <= S_BRANCH;
            default:           r_state <= S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_WB;
        S_WB, S_BRANCH: begin
          if (!w_sat) r_retired <= r_retired + 1'b1;
          r_state <= bus.run_i ? S_FETCH : S_IDLE;
        end
        S_TRAP: r_state <= S_TRAP;
      endcase
    end
  end

  // Moore decode; only the branch PC load looks at a live input.
  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_reg_dst   = 1'b0;
    w_src_a     = 1'b0;
    w_src_b     = 2'b00;
    w_alu_op    = 3'b000;
    w_pc_src    = 1'b0;
    w_illegal   = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_src_b    = 2'b01;
      end
      S_DECODE: w_src_b = 2'b11;
      S_EXEC_R: begin
        w_src_a  = 1'b1;
        w_alu_op = 3'b010;
      end
      S_EXEC_I: begin
        w_src_a  = 1'b1;
        w_src_b  = 2'b10;
        w_alu_op = w_exec_op;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = w_is_r;
        w_src_a     = 1'b1;
        w_src_b     = w_exec_b;
        w_alu_op    = w_exec_op;
      end
      S_BRANCH: begin
        w_src_a    = 1'b1;
        w_alu_op   = 3'b001;
        w_pc_src   = 1'b1;
        w_pc_write = bus.zero_i;
      end
      S_TRAP: w_illegal = 1'b1;
    endcase
  end

  assign bus.pc_write_o  = w_pc_write;
  assign bus.ir_write_o  = w_ir_write;
  assign bus.reg_write_o = w_reg_write;
  assign bus.reg_dst_o   = w_reg_dst;
  assign bus.alu_src_a_o = w_src_a;
  assign bus.alu_src_b_o = w_src_b;
  assign bus.alu_op_o    = w_alu_op;
  assign bus.pc_src_o    = w_pc_src;
  assign bus.illegal_o   = w_illegal;
  assign bus.state_o     = r_state;
  assign bus.retired_o   = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised self-checking bench for multicycle_ctrl.
// A 2-bit-counter twin shares the stimulus to exercise saturation.
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;

  multicycle_ctrl_if #(.CNT_W(16)) bus1 ();
  multicycle_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus2.run_i      = bus1.run_i;
  assign bus2.instr_op_i = bus1.instr_op_i;
  assign bus2.zero_i     = bus1.zero_i;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_ret    = 0;
  bit parked   = 1;

  // Instruction-level model: which control steps an opcode walks through.
  function automatic int trace_len(logic [5:0] op);
    if (op == 6'd0 || op == 6'b001000 || op == 6'b001010)
      return 4;
    if (op == 6'b000100)
      return 3;
    return 3;
  endfunction

  function automatic logic [2:0] trace_st(logic [5:0] op, int k);
    logic [2:0] third;
    if (k == 0) return 3'd1;
    if (k == 1) return 3'd2;
    if (op == 6'd0)
      third = 3'd3;
    else if (op == 6'b001000 || op == 6'b001010)
      third = 3'd4;
    else if (op == 6'b000100)
      third = 3'd5;
    else
      third = 3'd7;
    if (k == 2) return third;
    return 3'd6;
  endfunction

  // {pc_w, ir_w, reg_w, reg_dst, src_a, src_b, alu_op, pc_src, illegal}
  function automatic logic [12:0] exp_vec(logic [2:0] st,
                                          logic [5:0] op,
                                          logic z);
    logic [2:0] eop;
    logic [1:0] eb;
    eop = (op == 6'd0) ? 3'b010 :
          (op == 6'b001010) ? 3'b011 : 3'b000;
    eb  = (op == 6'd0) ? 2'b00 : 2'b10;
    case (st)
      3'd1: return 13'b1_1_0_0_0_01_000_0_0;
      3'd2: return 13'b0_0_0_0_0_11_000_0_0;
      3'd3: return 13'b0_0_0_0_1_00_010_0_0;
      3'd4: return {5'b0_0_0_0_1, 2'b10, eop, 2'b0_0};
      3'd5: return {z, 4'b0_0_0_1, 2'b00, 3'b001, 2'b1_0};
      3'd6: return {3'b0_0_1, op == 6'd0, 1'b1, eb, eop, 2'b0_0};
      3'd7: return 13'b0_0_0_0_0_00_000_0_1;
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [12:0] obs_vec();
    return {bus1.pc_write_o, bus1.ir_write_o, bus1.reg_write_o,
            bus1.reg_dst_o, bus1.alu_src_a_o, bus1.alu_src_b_o,
            bus1.alu_op_o, bus1.pc_src_o, bus1.illegal_o};
  endfunction

  function automatic int sat3(int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic go();
    bus1.run_i = 1'b1;
    #1;
    checks++;
    if (bus1.state_o !== 3'd0) begin
      failures++;
      $display("FAIL go_idle state=%0d exp=0", bus1.state_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus1.state_o !== 3'd1) begin
      failures++;
      $display("FAIL go_fetch state=%0d exp=1", bus1.state_o);
    end
    parked = 0;
  endtask

  // Runs one legal instruction from FETCH; run at the retire step decides
  // whether the next visible state is FETCH or IDLE.
  task automatic run_instr(string tag, logic [5:0] op, logic z,
                           bit run_end, bit drop_mid, bit noise);
    int len;
    logic [2:0] es;
    logic [12:0] ev;
    logic [12:0] ov;
    if (parked) go();
    bus1.instr_op_i = op;
    bus1.zero_i     = z;
    len = trace_len(op);
    for (int k = 0; k < len; k++) begin
      if (k == len - 1)
        bus1.run_i = run_end;
      else if (drop_mid && k == 2)
        bus1.run_i = 1'b0;
      else if (noise)
        bus1.run_i = 1'($urandom);
      #1;
      es = trace_st(op, k);
      ev = exp_vec(es, op, z);
      ov = obs_vec();
      checks++;
      if (bus1.state_o !== es) begin
        failures++;
        $display("FAIL %s_state k=%0d got=%0d exp=%0d",
                 tag, k, bus1.state_o, es);
      end
      checks++;
      if (ov !== ev) begin
        failures++;
        $display("FAIL %s_outs k=%0d got=%b exp=%b", tag, k, ov, ev);
      end
      checks++;
      if (bus1.ir_write_o === 1'b1 && bus1.reg_write_o === 1'b1) begin
        failures++;
        $display("FAIL %s_excl k=%0d got=11 exp=not_both", tag, k);
      end
      @(negedge clk);
    end
    n_ret++;
    #1;
    checks++;
    if (bus1.retired_o !== 16'(n_ret)) begin
      failures++;
      $display("FAIL %s_retired got=%0d exp=%0d",
               tag, bus1.retired_o, n_ret);
    end
    checks++;
    if (bus2.retired_o !== 2'(sat3(n_ret))) begin
      failures++;
      $display("FAIL %s_retired_sat got=%0d exp=%0d",
               tag, bus2.retired_o, sat3(n_ret));
    end
    checks++;
    if (bus1.state_o !== (run_end ? 3'd1 : 3'd0)) begin
      failures++;
      $display("FAIL %s_next got=%0d exp=%0d",
               tag, bus1.state_o, run_end ? 1 : 0);
    end
    parked = !run_end;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.run_i = 1'b1;
    bus1.instr_op_i = 6'd0;
    bus1.zero_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus1.state_o !== 3'd0 || obs_vec() !== 13'd0) begin
      failures++;
      $display("FAIL reset_outs state=%0d outs=%b exp=0",
               bus1.state_o, obs_vec());
    end
    checks++;
    if (bus1.retired_o !== 16'd0 || bus2.retired_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_retired got=%0d exp=0", bus1.retired_o);
    end
    bus1.run_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus1.state_o !== 3'd0) begin
      failures++;
      $display("FAIL idle_hold state=%0d exp=0", bus1.state_o);
    end
    n_ret  = 0;
    parked = 1;
  endtask

  task automatic test_rtype();
    run_instr("rtype", 6'b000000, 1'b0, 1, 0, 0);
  endtask

  task automatic test_itype();
    run_instr("addi", 6'b001000, 1'b1, 1, 0, 0);
    run_instr("slti", 6'b001010, 1'b0, 1, 0, 0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 6'b000100, 1'b1, 1, 0, 0);
    run_instr("beq_not", 6'b000100, 1'b0, 1, 0, 0);
  endtask

  task automatic test_run_drop();
    run_instr("drop", 6'b000000, 1'b0, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus1.state_o !== 3'd0) begin
      failures++;
      $display("FAIL drop_park state=%0d exp=0", bus1.state_o);
    end
    go();
    run_instr("after_drop", 6'b001000, 1'b0, 1, 0, 0);
  endtask

  task automatic test_trap();
    if (parked) go();
    bus1.instr_op_i = 6'b100011;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus1.run_i = 1'($urandom);
      #1;
      checks++;
      if (bus1.state_o !== 3'd7 || obs_vec() !== 13'd1) begin
        failures++;
        $display("FAIL trap_hold i=%0d state=%0d outs=%b exp=7/1",
                 i, bus1.state_o, obs_vec());
      end
      checks++;
      if (bus1.retired_o !== 16'(n_ret)) begin
        failures++;
        $display("FAIL trap_retired got=%0d exp=%0d",
                 bus1.retired_o, n_ret);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.state_o !== 3'd0 || bus1.illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_exit state=%0d ill=%b exp=0/0",
               bus1.state_o, bus1.illegal_o);
    end
    bus1.run_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    n_ret  = 0;
    parked = 1;
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    ops[0] = 6'b000000;
    ops[1] = 6'b001000;
    ops[2] = 6'b001010;
    ops[3] = 6'b000100;
    for (int i = 0; i < 20; i++) begin
      run_instr("rand", ops[$urandom_range(3)], 1'($urandom),
                ($urandom_range(3) != 0), 0, 1);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] ops [4];
    ops[0] = 6'b000000;
    ops[1] = 6'b001000;
    ops[2] = 6'b001010;
    ops[3] = 6'b000100;
    if (parked) go();
    bus1.instr_op_i = 6'b000000;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.state_o !== 3'd0 || obs_vec() !== 13'd0) begin
      failures++;
      $display("FAIL async_outs state=%0d outs=%b exp=0",
               bus1.state_o, obs_vec());
    end
    checks++;
    if (bus1.retired_o !== 16'd0 || bus2.retired_o !== 2'd0) begin
      failures++;
      $display("FAIL async_retired got=%0d exp=0", bus1.retired_o);
    end
    bus1.run_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    n_ret  = 0;
    parked = 1;
    for (int i = 0; i < 5; i++)
      run_instr("sat", ops[$urandom_range(3)], 1'($urandom),
                (i != 4), 0, 0);
    checks++;
    if (bus2.retired_o !== 2'd3) begin
      failures++;
      $display("FAIL sat_final got=%0d exp=3", bus2.retired_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus1.run_i = 1'b0;
    bus1.instr_op_i = 6'd0;
    bus1.zero_i = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_run_drop();
    test_trap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
